fetch_unit: RTL

Instruction-fetch stage of the pipelined RISC-V CPU. Owns the program counter and issues word-aligned requests to instruction memory, tolerating any response latency of at least one cycle. Buffers returned words with their PCs and hands them to the IF/ID pipeline register over a valid/ready handshake. Accepts branch/jump redirects from later stages, squashing buffered and in-flight fetches.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 44 ++++
 rtl/fetch_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the pipelined RISC-V CPU.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; head is visible combinationally.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output fetch_entry_t                 head,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues credit-limited memory requests,
// buffers tagged responses and squashes stale fetches on redirect.
module fetch_unit #(
  parameter int              XLEN     = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
);

  import cpu_pkg::*;

  localparam int CW = $clog2(DEPTH+1);
  typedef logic [CW-1:0] cnt_t;

  logic [XLEN-1:0] pc;
  logic            running;
  cnt_t            discard;
  cnt_t            inflight;
  cnt_t            occupancy;
  logic [CW:0]     credit_used;

  fetch_entry_t    buf_head;
  fetch_entry_t    tag_head;
  logic            buf_empty;
  logic            tag_empty;
  logic            req_fire;
  logic            rsp_owned;
  logic            rsp_keep;
  logic            out_fire;
  logic            unused_tag;

  assign credit_used    = {1'b0, inflight} + {1'b0, occupancy};
  assign imem_req_valid = running && !redirect_valid && (int'(credit_used) < DEPTH);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response belongs to a live request only when no squashed ones are still owed.
  assign rsp_owned = imem_rsp_valid && (discard == '0);
  assign rsp_keep  = rsp_owned && !redirect_valid;

  assign out_valid = !buf_empty && !redirect_valid;
  assign out_fire  = out_valid && out_ready;
  assign out_instr = buf_empty ? '0 : buf_head.instr;
  assign out_pc    = buf_empty ? '0 : buf_head.pc;

  assign unused_tag = ^{tag_head.instr, tag_empty, redirect_pc[1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      running <= 1'b0;
      discard <= '0;
    end else begin
      running <= 1'b1;
      if (redirect_valid) begin
        pc      <= {redirect_pc[XLEN-1:2], 2'b00};
        discard <= discard + inflight - cnt_t'(imem_rsp_valid);
      end else begin
        if (req_fire) pc <= pc + XLEN'(4);
        if (imem_rsp_valid && (discard != '0)) discard <= discard - 1'b1;
      end
    end
  end

  // The pc-tag queue occupancy is the count of live (unsquashed) in-flight requests.
  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_tag_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_fire),
    .push_data ('{pc: pc, instr: '0}),
    .pop       (rsp_owned),
    .flush     (redirect_valid),
    .head      (tag_head),
    .empty     (tag_empty),
    .count     (inflight)
  );

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rsp_keep),
    .push_data ('{pc: tag_head.pc, instr: imem_rsp_data}),
    .pop       (out_fire),
    .flush     (redirect_valid),
    .head      (buf_head),
    .empty     (buf_empty),
    .count     (occupancy)
  );

endmodule
